// File: rtl/cc_resp_checker.sv
// In-order read-response scoreboard for the L1 cache processor-side port.
// Define CC_CHK_FIRST_ERR_EN to build the first-mismatch capture registers.
module cc_resp_checker #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 8,
    parameter int EXP_ENTRIES = 256,
    parameter int MAX_LAT     = 16,
    parameter int CW          = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mon_read,
    input  logic                           mon_write,
    input  logic                           mon_ready,
    input  logic [AW-1:0]                  mon_addr,
    input  logic [DW/8-1:0]                mon_be,
    input  logic [DW-1:0]                  mon_wdata,
    input  logic [DW-1:0]                  mon_rdata,
    input  logic                           mon_rvalid,
    input  logic                           exp_we,
    input  logic [$clog2(EXP_ENTRIES)-1:0] exp_idx,
    input  logic [DW-1:0]                  exp_data,
    input  logic                           clr,
    output logic [$clog2(DEPTH):0]         pending,
    output logic [CW-1:0]                  rd_count,
    output logic [CW-1:0]                  err_count,
    output logic                           ovf_err,
    output logic                           unexp_err,
    output logic                           tmo_err,
    output logic                           proto_err,
    output logic [AW-1:0]                  first_err_addr,
    output logic [DW-1:0]                  first_err_exp,
    output logic [DW-1:0]                  first_err_act
);
    localparam int NB  = DW / 8;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = $clog2(EXP_ENTRIES);
    localparam int PW  = $clog2(DEPTH);
    localparam int AGW = $clog2(MAX_LAT + 1);

    logic [DW-1:0]  image    [EXP_ENTRIES];
    logic [DW-1:0]  fifo_exp [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [PW:0]    cnt;
    logic [AGW-1:0] age;

    logic [IW-1:0] img_idx;
    logic acc, rd_acc, wr_acc, proto;
    logic fifo_empty, fifo_full;
    logic rsp_pop, tmo_pop, pop, push, unexp, ovf, mismatch;
    logic [2:0]  err_inc;
    logic [CW:0] err_sum;

    assign img_idx = mon_addr[BW +: IW];

    // A clr cycle discards whatever the port accepted in that cycle.
    assign acc    = mon_ready & (mon_read | mon_write) & ~clr;
    assign rd_acc = acc & mon_read & ~mon_write;
    assign wr_acc = acc & mon_write & ~mon_read;
    assign proto  = acc & mon_read & mon_write;

    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == (PW+1)'(DEPTH));

    assign rsp_pop  = mon_rvalid & ~fifo_empty;
    assign unexp    = mon_rvalid & fifo_empty;
    assign tmo_pop  = ~fifo_empty & ~mon_rvalid & (age == AGW'(MAX_LAT - 1));
    assign pop      = rsp_pop | tmo_pop;
    assign ovf      = rd_acc & fifo_full & ~pop;
    assign push     = rd_acc & ~ovf;
    assign mismatch = rsp_pop & (fifo_exp[rd_ptr] != mon_rdata);

    // Only proto can coincide with one of the other (mutually exclusive) errors.
    assign err_inc = 3'(mismatch) + 3'(unexp) + 3'(ovf) + 3'(tmo_pop) + 3'(proto);
    assign err_sum = {1'b0, err_count} + {{(CW-2){1'b0}}, err_inc};

    // NOTE: storage arrays carry no reset; validity comes from cnt and the preload.
    always_ff @(posedge clk) begin
        if (exp_we)
            image[exp_idx] <= exp_data;
        // Later assignment wins, so the monitored write overrides enabled lanes.
        if (wr_acc)
            for (int b = 0; b < NB; b++)
                if (mon_be[b])
                    image[img_idx][8*b +: 8] <= mon_wdata[8*b +: 8];
        if (push)
            fifo_exp[wr_ptr] <= image[img_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            age       <= '0;
            rd_count  <= '0;
            err_count <= '0;
            ovf_err   <= 1'b0;
            unexp_err <= 1'b0;
            tmo_err   <= 1'b0;
            proto_err <= 1'b0;
        end else if (clr) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            age       <= '0;
            rd_count  <= '0;
            err_count <= '0;
            ovf_err   <= 1'b0;
            unexp_err <= 1'b0;
            tmo_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (pop || fifo_empty)
                age <= '0;
            else
                age <= age + 1'b1;
            if (rsp_pop && rd_count != '1)
                rd_count <= rd_count + 1'b1;
            err_count <= err_sum[CW] ? '1 : err_sum[CW-1:0];
            ovf_err   <= ovf_err   | ovf;
            unexp_err <= unexp_err | unexp;
            tmo_err   <= tmo_err   | tmo_pop;
            proto_err <= proto_err | proto;
        end
    end

    assign pending = cnt;

`ifdef CC_CHK_FIRST_ERR_EN
    logic [AW-1:0] fifo_addr [DEPTH];
    logic          first_seen;

    always_ff @(posedge clk) begin
        if (push)
            fifo_addr[wr_ptr] <= mon_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_seen     <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (clr) begin
            first_seen     <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (mismatch && !first_seen) begin
            first_seen     <= 1'b1;
            first_err_addr <= fifo_addr[rd_ptr];
            first_err_exp  <= fifo_exp[rd_ptr];
            first_err_act  <= mon_rdata;
        end
    end
`else
    logic unused_addr;
    assign unused_addr    = ^mon_addr;
    assign first_err_addr = '0;
    assign first_err_exp  = '0;
    assign first_err_act  = '0;
`endif

endmodule

// File: tb/tb_cc_resp_checker.sv
// Self-checking bench for cc_resp_checker: directed vector table, corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_cc_resp_checker;
    localparam int AW = 32, DW = 32, DEPTH = 8, EXP_ENTRIES = 256, MAX_LAT = 16, CW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           mon_read, mon_write, mon_ready, mon_rvalid, exp_we, clr;
    logic [AW-1:0]  mon_addr;
    logic [3:0]     mon_be;
    logic [DW-1:0]  mon_wdata, mon_rdata, exp_data;
    logic [7:0]     exp_idx;
    logic [3:0]     pending;
    logic [CW-1:0]  rd_count, err_count;
    logic           ovf_err, unexp_err, tmo_err, proto_err;
    logic [AW-1:0]  first_err_addr;
    logic [DW-1:0]  first_err_exp, first_err_act;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_resp_checker #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .EXP_ENTRIES(EXP_ENTRIES), .MAX_LAT(MAX_LAT), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .mon_read(mon_read), .mon_write(mon_write), .mon_ready(mon_ready),
        .mon_addr(mon_addr), .mon_be(mon_be), .mon_wdata(mon_wdata),
        .mon_rdata(mon_rdata), .mon_rvalid(mon_rvalid),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .clr(clr),
        .pending(pending), .rd_count(rd_count), .err_count(err_count),
        .ovf_err(ovf_err), .unexp_err(unexp_err), .tmo_err(tmo_err), .proto_err(proto_err),
        .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_act(first_err_act)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: outstanding reads as a queue of {address, snapshot}.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_rd, m_err, m_age;
    bit          m_ovf, m_unexp, m_tmo, m_proto, m_first;
    logic [31:0] m_fa, m_fe, m_fx;
    logic [31:0] m_img [EXP_ENTRIES];

    function automatic void model_reset();
        q.delete();
        m_rd = 0; m_err = 0; m_age = 0;
        m_ovf = 0; m_unexp = 0; m_tmo = 0; m_proto = 0; m_first = 0;
        m_fa = '0; m_fe = '0; m_fx = '0;
    endfunction

    task automatic model_step();
        bit          acc, was_empty;
        int          idx;
        logic [31:0] snap;
        ent_t        h;
        acc  = mon_ready && (mon_read || mon_write) && !clr;
        idx  = int'(mon_addr[9:2]);
        snap = m_img[idx];
        if (clr) begin
            model_reset();
        end else begin
            was_empty = (q.size() == 0);
            if (acc && mon_read && mon_write) begin
                m_proto = 1; m_err++;
            end
            if (mon_rvalid) begin
                if (was_empty) begin
                    m_unexp = 1; m_err++;
                end else begin
                    h = q.pop_front();
                    m_rd++;
                    m_age = 0;
                    if (h.data !== mon_rdata) begin
                        m_err++;
                        if (!m_first) begin
                            m_first = 1; m_fa = h.addr; m_fe = h.data; m_fx = mon_rdata;
                        end
                    end
                end
            end else if (!was_empty) begin
                m_age++;
                if (m_age == MAX_LAT) begin
                    m_tmo = 1; m_err++;
                    void'(q.pop_front());
                    m_age = 0;
                end
            end
            if (acc && mon_read && !mon_write) begin
                if (q.size() == DEPTH) begin
                    m_ovf = 1; m_err++;
                end else begin
                    q.push_back('{mon_addr, snap});
                end
            end
        end
        if (exp_we)
            m_img[exp_idx] = exp_data;
        if (acc && mon_write && !mon_read)
            for (int b = 0; b < 4; b++)
                if (mon_be[b]) m_img[idx][8*b +: 8] = mon_wdata[8*b +: 8];
    endtask

    task automatic idle_inputs();
        mon_read = 0; mon_write = 0; mon_ready = 1; mon_rvalid = 0;
        mon_addr = '0; mon_be = '0; mon_wdata = '0; mon_rdata = '0;
        exp_we = 0; exp_idx = '0; exp_data = '0; clr = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pending"}, 64'(pending), 64'(q.size()));
        check({tag, ".rd_count"}, 64'(rd_count), 64'(m_rd));
        check({tag, ".err_count"}, 64'(err_count), 64'(m_err));
        check({tag, ".stickies"}, 64'({ovf_err, unexp_err, tmo_err, proto_err}),
              64'({m_ovf, m_unexp, m_tmo, m_proto}));
`ifdef CC_CHK_FIRST_ERR_EN
        check({tag, ".first_err"}, 64'({first_err_addr, first_err_exp} ^ {32'h0, first_err_act}),
              64'({m_fa, m_fe} ^ {32'h0, m_fx}));
`endif
    endtask

    typedef struct {
        bit          rd, wr, rdy, rv, ew;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, rdata, edata;
        int          e_pend, e_rd, e_err;
        logic [3:0]  e_sticky;   // {ovf, unexp, tmo, proto}
    } vec_t;

    function automatic vec_t mk(bit rd, bit wr, bit rdy, bit rv, bit ew, logic [31:0] addr,
                                logic [3:0] be, logic [31:0] wdata, logic [31:0] rdata,
                                logic [31:0] edata, int p, int r, int e, logic [3:0] s);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rdy = rdy; v.rv = rv; v.ew = ew; v.addr = addr;
        v.be = be; v.wdata = wdata; v.rdata = rdata; v.edata = edata;
        v.e_pend = p; v.e_rd = r; v.e_err = e; v.e_sticky = s;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        vecs[0]  = mk(0,0,1,0,1, 32'h10,        4'h0, 0,            0,            32'hDEADBEEF, 0,0,0, 4'b0000);
        vecs[1]  = mk(1,0,1,0,0, 32'h10,        4'h0, 0,            0,            0,            1,0,0, 4'b0000);
        vecs[2]  = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEADBEEF, 0,            0,1,0, 4'b0000);
        vecs[3]  = mk(0,1,1,0,0, 32'h10,        4'h3, 32'h00001234, 0,            0,            0,1,0, 4'b0000);
        vecs[4]  = mk(1,0,1,0,0, 32'h10,        4'h0, 0,            0,            0,            1,1,0, 4'b0000);
        vecs[5]  = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEAD1234, 0,            0,2,0, 4'b0000);
        vecs[6]  = mk(1,0,1,0,0, 32'h10,        4'h0, 0,            0,            0,            1,2,0, 4'b0000);
        vecs[7]  = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEADBEEF, 0,            0,3,1, 4'b0000);
        vecs[8]  = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEADBEEF, 0,            0,3,2, 4'b0100);
        vecs[9]  = mk(1,1,1,0,0, 32'h10,        4'hF, 32'hFFFFFFFF, 0,            0,            0,3,3, 4'b0101);
        vecs[10] = mk(1,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEAD1234, 0,            1,3,4, 4'b0101);
        vecs[11] = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'hDEAD1234, 0,            0,4,4, 4'b0101);
        vecs[12] = mk(1,0,0,0,0, 32'h10,        4'h0, 0,            0,            0,            0,4,4, 4'b0101);
        vecs[13] = mk(0,1,1,0,0, 32'h80000010,  4'h8, 32'h55000000, 0,            0,            0,4,4, 4'b0101);
        vecs[14] = mk(1,0,1,0,0, 32'h10,        4'h0, 0,            0,            0,            1,4,4, 4'b0101);
        vecs[15] = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'h55AD1234, 0,            0,5,4, 4'b0101);
        vecs[16] = mk(0,1,1,0,1, 32'h10,        4'h1, 32'h000000AA, 0,            32'h11111111, 0,5,4, 4'b0101);
        vecs[17] = mk(1,0,1,0,0, 32'h10,        4'h0, 0,            0,            0,            1,5,4, 4'b0101);
        vecs[18] = mk(0,0,1,1,0, 32'h10,        4'h0, 0,            32'h111111AA, 0,            0,6,4, 4'b0101);

        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("reset.pending", 64'(pending), 0);
        check("reset.counts", 64'({rd_count, err_count}), 0);
        check("reset.stickies", 64'({ovf_err, unexp_err, tmo_err, proto_err}), 0);
        check("reset.first_err", 64'(first_err_addr | first_err_exp | first_err_act), 0);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            idle_inputs();
            mon_read = vecs[i].rd; mon_write = vecs[i].wr; mon_ready = vecs[i].rdy;
            mon_rvalid = vecs[i].rv; exp_we = vecs[i].ew; mon_addr = vecs[i].addr;
            exp_idx = vecs[i].addr[9:2]; mon_be = vecs[i].be; mon_wdata = vecs[i].wdata;
            mon_rdata = vecs[i].rdata; exp_data = vecs[i].edata;
            step();
            check($sformatf("vec%0d.pending", i), 64'(pending), 64'(vecs[i].e_pend));
            check($sformatf("vec%0d.rd_count", i), 64'(rd_count), 64'(vecs[i].e_rd));
            check($sformatf("vec%0d.err_count", i), 64'(err_count), 64'(vecs[i].e_err));
            check($sformatf("vec%0d.stickies", i), 64'({ovf_err, unexp_err, tmo_err, proto_err}),
                  64'(vecs[i].e_sticky));
        end
`ifdef CC_CHK_FIRST_ERR_EN
        check("first_err_addr", 64'(first_err_addr), 64'h10);
        check("first_err_exp", 64'(first_err_exp), 64'hDEAD1234);
        check("first_err_act", 64'(first_err_act), 64'hDEADBEEF);
`else
        check("first_err_tied", 64'(first_err_addr | first_err_exp | first_err_act), 0);
`endif

        // Overflow: nine back-to-back reads into an eight-entry FIFO
        idle_inputs(); clr = 1; step();
        check("clr.err_count", 64'(err_count), 0);
        check("clr.stickies", 64'({ovf_err, unexp_err, tmo_err, proto_err}), 0);
        idle_inputs(); mon_read = 1; mon_addr = 32'h10;
        for (int i = 0; i < 8; i++) step();
        check("ovf.pending8", 64'(pending), 8);
        check("ovf.before", 64'(ovf_err), 0);
        step();
        check("ovf.pending", 64'(pending), 8);
        check("ovf.sticky", 64'(ovf_err), 1);
        check("ovf.err_count", 64'(err_count), 1);

        // Timeout on a lone read
        idle_inputs(); clr = 1; step();
        idle_inputs(); mon_read = 1; mon_addr = 32'h10; step();
        idle_inputs();
        for (int i = 0; i < MAX_LAT - 1; i++) step();
        check("tmo.early", 64'({tmo_err, pending}), 64'({1'b0, 4'd1}));
        step();
        check("tmo.sticky", 64'(tmo_err), 1);
        check("tmo.pending", 64'(pending), 0);
        check("tmo.err_count", 64'(err_count), 1);
        check("tmo.rd_count", 64'(rd_count), 0);

        // Asynchronous reset with four reads outstanding
        idle_inputs(); clr = 1; step();
        idle_inputs(); mon_read = 1; mon_addr = 32'h10;
        for (int i = 0; i < 4; i++) step();
        check("rst.pending4", 64'(pending), 4);
        idle_inputs();
        #2 reset = 1;
        model_reset();
        #1;
        check("rst.async", 64'({pending, rd_count, err_count, ovf_err, unexp_err, tmo_err, proto_err}), 0);
        @(posedge clk); #1 reset = 0;
        mon_rvalid = 1; mon_rdata = 32'h111111AA; step();
        check("rst.unexp", 64'({unexp_err, err_count}), 64'({1'b1, 16'd1}));

        // clr keeps the expected image
        idle_inputs(); clr = 1; step();
        check("clr2.counts", 64'({rd_count, err_count, unexp_err}), 0);
        idle_inputs(); mon_read = 1; mon_addr = 32'h10; step();
        idle_inputs(); mon_rvalid = 1; mon_rdata = 32'h111111AA; step();
        check("clr2.reread", 64'({rd_count, err_count}), 64'({16'd1, 16'd0}));

        // Randomized traffic against the model
        idle_inputs(); clr = 1; step();
        for (int i = 0; i < EXP_ENTRIES; i++) begin
            idle_inputs(); exp_we = 1; exp_idx = 8'(i); exp_data = $urandom; step();
        end
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            mon_ready  = ($urandom_range(0, 9) < 8);
            mon_read   = ($urandom_range(0, 99) < 35);
            mon_write  = ($urandom_range(0, 99) < 25);
            mon_addr   = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} | {22'h0, 4'($urandom), 6'($urandom)};
            mon_be     = 4'($urandom);
            mon_wdata  = $urandom;
            exp_we     = ($urandom_range(0, 99) < 5);
            exp_idx    = 8'($urandom);
            exp_data   = $urandom;
            clr        = ($urandom_range(0, 199) == 0);
            if (q.size() != 0) begin
                mon_rvalid = ($urandom_range(0, 99) < 40);
                mon_rdata  = q[0].data ^ (($urandom_range(0, 9) == 0) ? 32'(1 << $urandom_range(0, 31)) : 32'h0);
            end else begin
                mon_rvalid = ($urandom_range(0, 99) < 3);
                mon_rdata  = $urandom;
            end
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
